piso_word_feeder: RTL and testbench

//  Buffers 16-bit words from the sample/packing logic in a small FIFO and feeds them
//  one at a time to the PISO serializer. Uses the PISO valid_data/piso_done handshake.

---
 rtl/piso_word_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_piso_word_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_word_feeder.sv
// ---------------------------------------------------------------------------
// piso_word_feeder
//
// Purpose:
//   Queues DATA_W-bit words from the sample/packing logic in a small circular
//   FIFO and hands them one at a time to a PISO serializer. A word is loaded
//   with a one-cycle tx_valid strobe. The next word is not offered until the
//   PISO reports tx_done, an optional idle gap has elapsed, or the wait for
//   tx_done has timed out. Sticky status flags record dropped writes and
//   abandoned words. A 16-bit counter records the number of words sent.
//
// Parameters:
//   DATA_W   word width, matches the PISO parallel input
//   DEPTH    FIFO depth in words (power of 2, >= 2)
//   GAP      idle cycles after each tx_done before the next load (0 = none)
//   TIMEOUT  cycles allowed in WAIT_DONE before the word is abandoned (>= 18)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   wr_en        enqueue wr_data this cycle
//   wr_data      word to enqueue
//   full         FIFO holds DEPTH words
//   empty        FIFO holds no words
//   level        FIFO occupancy
//   tx_data      word presented to the PISO, held until the next load
//   tx_valid     one-cycle load strobe to the PISO
//   tx_done      PISO finished shifting the last bit
//   busy         FSM is not in IDLE
//   overflow     sticky, a write was dropped because the FIFO was full
//   timeout_err  sticky, tx_done did not arrive within TIMEOUT cycles
//   words_sent   words completed with tx_done, wraps at 16 bits
// ---------------------------------------------------------------------------
module piso_word_feeder #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_done,
  output logic                       busy,
  output logic                       overflow,
  output logic                       timeout_err,
  output logic [15:0]                words_sent
);

  // Address width and pointer width. The pointer carries one extra bit so
  // that full and empty can be told apart without a separate counter.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // The timeout counter must reach TIMEOUT-1. The gap counter must reach
  // GAP-1 and is kept at least one bit wide, so that GAP=0 still elaborates.
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]       words_q, words_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic [LW-1:0]     level_w;
  logic              full_w;
  logic              empty_w;
  logic              pop;
  logic              wr_accept;

  // Occupancy is derived from the registered pointers. The pointers wrap
  // naturally modulo 2*DEPTH, so the difference stays correct across a wrap.
  assign level_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (level_w == FULL_LEVEL);
  assign empty_w = (level_w == '0);

  // The head is popped only when IDLE launches a new word. A write to a
  // full FIFO is still accepted when that pop frees a slot in the same cycle.
  assign pop       = (state_q == S_IDLE) && !empty_w;
  assign wr_accept = wr_en && (!full_w || pop);

  // Pointer and sticky overflow next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + LW'(wr_accept);
    rd_ptr_d   = rd_ptr_q + LW'(pop);
    overflow_d = overflow_q | (wr_en && full_w && !pop);
  end

  // Transmit FSM next-state logic. tx_valid is registered, so it rises in
  // the cycle spent in LOAD and drops as WAIT_DONE begins. In the last
  // counted cycle, tx_done takes priority over the timeout.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    words_d    = words_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          tx_data_d  = mem[rd_ptr_q[AW-1:0]];
          tx_valid_d = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          words_d = words_q + 16'd1;
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage has no reset. Reset clears the pointers, which discards
  // the stored words without having to clear the array.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // State, pointers, counters and flags. Reset abandons any word in flight
  // and does not count it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign full        = full_w;
  assign empty       = empty_w;
  assign level       = level_w;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign words_sent  = words_q;

endmodule

// File: tb/tb_piso_word_feeder.sv
// Self-checking bench for piso_word_feeder with the default parameters
// (DATA_W=16, DEPTH=4, GAP=1, TIMEOUT=32). A simple PISO model answers each
// load with tx_done after SHIFT cycles. Words expected on tx_data are queued
// when they are written and are compared when tx_valid appears.
module tb_piso_word_feeder;

  localparam int SHIFT   = 16;
  localparam int TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_done;
  logic        busy;
  logic        overflow;
  logic        timeout_err;
  logic [15:0] words_sent;

  int          checkCount = 0;
  int          failCount  = 0;
  logic [15:0] expQ[$];
  logic        prevValid  = 1'b0;
  logic        pisoHang   = 1'b0;
  int          pisoCnt    = 0;
  int          validSeen  = 0;

  piso_word_feeder #(
    .DATA_W(16), .DEPTH(4), .GAP(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done),
    .busy(busy), .overflow(overflow), .timeout_err(timeout_err),
    .words_sent(words_sent)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one write that lands on the next rising edge. The call starts and
  // ends on a falling edge. Accepted words are queued as expected output.
  task automatic applyStimulus(input logic [15:0] data, input bit accepted);
    wr_en   = 1'b1;
    wr_data = data;
    if (accepted) expQ.push_back(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Holds rst high for the given number of edges and drops every pending
  // expected word, because reset discards the FIFO contents.
  task automatic applyReset(input int cycles);
    rst = 1'b1;
    expQ.delete();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits, with a cycle bound, until words_sent reaches the target value.
  // Checking words_sent afterwards also reports the case where the bound ran out.
  task automatic waitWordsSent(input logic [15:0] target, input int budget);
    int n = 0;
    while (words_sent !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("words_sent", 32'(words_sent), 32'(target));
  endtask

  // Waits, with a cycle bound, until busy drops.
  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
  endtask

  // PISO model. A load seen on tx_valid produces a one-cycle tx_done SHIFT
  // cycles later. Setting pisoHang makes it ignore loads.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        pisoCnt = 0;
      end else if (pisoCnt > 0) begin
        pisoCnt--;
        if (pisoCnt == 0) tx_done = 1'b1;
      end else if (tx_valid === 1'b1 && !pisoHang) begin
        pisoCnt = SHIFT;
      end
    end
  end

  // Scoreboard. Each tx_valid pulse must last exactly one cycle and must carry
  // the oldest word that is still expected.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_valid === 1'b1) begin
        validSeen++;
        checkOutput("valid_one_cycle", 32'(prevValid), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("expected_word_pending", 32'(expQ.size()), 32'd1);
        end else begin
          checkOutput("tx_data_order", 32'(tx_data), 32'(expQ.pop_front()));
        end
      end
      prevValid = !rst && (tx_valid === 1'b1);
    end
  end

  // Stops the run if the test sequence does not finish within the time limit.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int validBefore;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset with wr_en held high: nothing is written and all outputs are cleared.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    repeat (2) @(negedge clk);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_words_sent", 32'(words_sent), 32'd0);
    wr_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_level", 32'(level), 32'd0);

    // Single word. tx_valid rises in the second cycle after the write edge,
    // and busy stays high for the one gap cycle after tx_done.
    $display("[TB] single word");
    applyStimulus(16'hA5C3, 1'b1);
    checkOutput("latency_not_yet", 32'(tx_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_valid", 32'(tx_valid), 32'd1);
    checkOutput("single_tx_data", 32'(tx_data), 32'hA5C3);
    waitWordsSent(16'd1, 100);
    checkOutput("gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("after_gap_busy", 32'(busy), 32'd0);
    checkOutput("after_gap_empty", 32'(empty), 32'd1);
    checkOutput("hold_tx_data", 32'(tx_data), 32'hA5C3);

    // Burst of six words. Word 1 is popped on the second edge, so words 2-5
    // fill the FIFO and word 6 is dropped.
    $display("[TB] burst");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(16'(i), i <= 5);
      if (i == 5) begin
        checkOutput("burst_full", 32'(full), 32'd1);
        checkOutput("burst_level", 32'(level), 32'd4);
        checkOutput("burst_no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    checkOutput("burst_overflow", 32'(overflow), 32'd1);
    checkOutput("burst_level_after_drop", 32'(level), 32'd4);
    waitWordsSent(16'd6, 400);
    waitIdle(20);
    checkOutput("burst_drained", 32'(expQ.size()), 32'd0);

    // Write in the same cycle as the IDLE pop while the FIFO is full.
    $display("[TB] push and pop together");
    applyReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(16'h1000 + 16'(i), 1'b1);
    checkOutput("pp_full_before", 32'(level), 32'd4);
    waitIdle(100);
    checkOutput("pp_level_at_idle", 32'(level), 32'd4);
    applyStimulus(16'h1005, 1'b1);
    checkOutput("pp_level_after", 32'(level), 32'd4);
    checkOutput("pp_no_overflow", 32'(overflow), 32'd0);
    checkOutput("pp_busy", 32'(busy), 32'd1);
    waitWordsSent(16'd6, 400);
    waitIdle(20);
    checkOutput("pp_drained", 32'(expQ.size()), 32'd0);

    // Timeout. The PISO model ignores the first load, the word is abandoned
    // TIMEOUT cycles after WAIT_DONE is entered, and the next word then goes
    // out normally.
    $display("[TB] timeout");
    applyReset(1);
    pisoHang = 1'b1;
    applyStimulus(16'h7001, 1'b1);
    applyStimulus(16'h7002, 1'b1);
    @(posedge clk);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_not_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    checkOutput("timeout_set", 32'(timeout_err), 32'd1);
    checkOutput("timeout_idle", 32'(busy), 32'd0);
    pisoHang = 1'b0;
    waitWordsSent(16'd1, 100);
    checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
    waitIdle(20);

    // Reset in WAIT_DONE with three words queued: the queued words are
    // dropped and no load follows.
    $display("[TB] reset mid-transfer");
    applyReset(1);
    checkOutput("mid_timeout_cleared", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(16'h2000 + 16'(i), 1'b1);
    checkOutput("mid_level_before", 32'(level), 32'd3);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    applyReset(1);
    checkOutput("mid_level", 32'(level), 32'd0);
    checkOutput("mid_empty", 32'(empty), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_words_sent", 32'(words_sent), 32'd0);
    validBefore = validSeen;
    repeat (40) @(negedge clk);
    checkOutput("mid_no_valid", 32'(validSeen - validBefore), 32'd0);
    checkOutput("final_scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
